// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter between instruction fetch and the load/store unit.
// Define MEMCTRL_RR_EN to alternate contended grants; otherwise LS has fixed priority.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_done_out,
  output logic [31:0]       if_data_out,
  input  logic              ls_req_in,
  input  logic              ls_we_in,
  input  logic [1:0]        ls_size_in,
  input  logic [ADDR_W-1:0] ls_addr_in,
  input  logic [31:0]       ls_wdata_in,
  output logic              ls_done_out,
  output logic [31:0]       ls_rdata_out,
  input  logic              flush_in,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  // Handshake: a requester holds req high until its done pulse; done is a
  // single rdy-qualified cycle and the controller never grants in that cycle.

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          len_q, len_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                owner_if_q, owner_if_d;
  logic [31:0]         buf_q, buf_d;
  logic [31:0]         if_data_q, if_data_d;
  logic [31:0]         ls_data_q, ls_data_d;
`ifdef MEMCTRL_RR_EN
  logic                rr_q, rr_d;
`endif

  logic                grant_ls, grant_if, if_ok;
  logic                issue, done_hit, io_block, flush_if, last_byte;
  logic [ADDR_W-1:0]   cur_addr;
  logic [31:0]         asm_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    owner_if_d = owner_if_q;
    buf_d      = buf_q;
    if_data_d  = if_data_q;
    ls_data_d  = ls_data_q;
`ifdef MEMCTRL_RR_EN
    rr_d       = rr_q;
`endif
    grant_ls   = 1'b0;
    grant_if   = 1'b0;
    issue      = 1'b0;
    done_hit   = 1'b0;
    if_ok      = if_req_in && !flush_in;
    last_byte  = (cnt_q == len_q);
    cur_addr   = base_q + ADDR_W'(cnt_q);
    io_block   = (cur_addr[17:16] == 2'b11) && io_buffer_full;
    flush_if   = flush_in && owner_if_q;

    // Last byte is still on mem_din during the done cycle, so splice it in.
    asm_data = buf_q;
    case (len_q)
      3'd1:    asm_data[7:0]   = mem_din;
      3'd2:    asm_data[15:8]  = mem_din;
      default: asm_data[31:24] = mem_din;
    endcase

    unique case (state_q)
      IDLE: begin
        grant_ls = ls_req_in;
        grant_if = if_ok && !ls_req_in;
`ifdef MEMCTRL_RR_EN
        if (ls_req_in && if_ok) begin
          grant_ls = !rr_q;
          grant_if = rr_q;
          rr_d     = !rr_q;
        end
`endif
        if (grant_ls) begin
          base_d     = ls_addr_in;
          wdata_d    = ls_wdata_in;
          owner_if_d = 1'b0;
          cnt_d      = 3'd0;
          buf_d      = 32'd0;
          state_d    = ls_we_in ? WRITE : READ;
          case (ls_size_in)
            2'b00:   len_d = 3'd1;
            2'b01:   len_d = 3'd2;
            default: len_d = 3'd4;
          endcase
        end else if (grant_if) begin
          base_d     = if_addr_in;
          owner_if_d = 1'b1;
          cnt_d      = 3'd0;
          buf_d      = 32'd0;
          len_d      = 3'd4;
          state_d    = READ;
        end
      end
      READ: begin
        if (flush_if) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (last_byte) begin
          done_hit = 1'b1;
          state_d  = IDLE;
          cnt_d    = 3'd0;
          if (owner_if_q) if_data_d = asm_data;
          else            ls_data_d = asm_data;
        end else begin
          issue = 1'b1;
          if (cnt_q != 3'd0) buf_d[{cnt_q - 3'd1, 3'b000} +: 8] = mem_din;
          cnt_d = cnt_q + 3'd1;
        end
      end
      WRITE: begin
        if (last_byte) begin
          done_hit = 1'b1;
          state_d  = IDLE;
          cnt_d    = 3'd0;
        end else begin
          issue = 1'b1;
          if (!io_block) cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      base_q     <= '0;
      wdata_q    <= 32'd0;
      owner_if_q <= 1'b0;
      buf_q      <= 32'd0;
      if_data_q  <= 32'd0;
      ls_data_q  <= 32'd0;
`ifdef MEMCTRL_RR_EN
      rr_q       <= 1'b0;
`endif
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      owner_if_q <= owner_if_d;
      buf_q      <= buf_d;
      if_data_q  <= if_data_d;
      ls_data_q  <= ls_data_d;
`ifdef MEMCTRL_RR_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign mem_a        = issue ? cur_addr : '0;
  assign mem_dout     = (issue && state_q == WRITE) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'd0;
  assign mem_wr       = issue && (state_q == WRITE) && !io_block && rdy;
  assign if_done_out  = done_hit && rdy && owner_if_q;
  assign ls_done_out  = done_hit && rdy && !owner_if_q;
  assign if_data_out  = if_done_out ? asm_data : if_data_q;
  assign ls_rdata_out = (ls_done_out && state_q == READ) ? asm_data : ls_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl: fetch, store/load, contention, flush, I/O stall,
// pause and reset abort, against a byte RAM model that pauses with rdy.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req_in, ls_req_in, ls_we_in, flush_in, io_buffer_full;
  logic [31:0] if_addr_in, ls_addr_in, ls_wdata_in;
  logic [1:0]  ls_size_in;
  logic        if_done_out, ls_done_out, mem_wr;
  logic [31:0] if_data_out, ls_rdata_out, mem_a;
  logic [7:0]  mem_din, mem_dout;
  logic [7:0]  ram [0:4095];

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_done_out(if_done_out), .if_data_out(if_data_out),
    .ls_req_in(ls_req_in), .ls_we_in(ls_we_in), .ls_size_in(ls_size_in),
    .ls_addr_in(ls_addr_in), .ls_wdata_in(ls_wdata_in),
    .ls_done_out(ls_done_out), .ls_rdata_out(ls_rdata_out),
    .flush_in(flush_in), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) ram[mem_a[11:0]] = mem_dout;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // drive point: just after the rising edge; checks sample on the falling edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1;
    if_req_in = 0; ls_req_in = 0; ls_we_in = 0; flush_in = 0; io_buffer_full = 0;
    if_addr_in = 0; ls_addr_in = 0; ls_wdata_in = 0; ls_size_in = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_a, mem_dout, mem_wr, if_done_out, ls_done_out} !== 43'd0) begin
      failures++;
      $display("FAIL reset_ctrl got mem_a=%h dout=%h wr=%b ifd=%b lsd=%b exp all 0",
               mem_a, mem_dout, mem_wr, if_done_out, ls_done_out);
    end
    checks++;
    if (if_data_out !== 32'd0 || ls_rdata_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got if=%h ls=%h exp 0", if_data_out, ls_rdata_out);
    end
  endtask

  task automatic test_fetch();
    cyc();
    if_addr_in = 32'h100; if_req_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (k <= 4) begin
        if (mem_a !== 32'h100 + k - 1 || mem_wr !== 1'b0 || if_done_out !== 1'b0) begin
          failures++;
          $display("FAIL fetch_addr k=%0d got a=%h wr=%b done=%b exp a=%h wr=0 done=0",
                   k, mem_a, mem_wr, if_done_out, 32'h100 + k - 1);
        end
      end else if (if_done_out !== 1'b1 || if_data_out !== 32'h00000513 || mem_a !== 32'd0) begin
        failures++;
        $display("FAIL fetch_done got done=%b data=%h a=%h exp done=1 data=00000513 a=0",
                 if_done_out, if_data_out, mem_a);
      end
    end
    cyc();
    if_req_in = 1'b0;
    @(negedge clk);
    checks++;
    if (if_done_out !== 1'b0 || if_data_out !== 32'h00000513) begin
      failures++;
      $display("FAIL fetch_hold got done=%b data=%h exp done=0 data=00000513", if_done_out, if_data_out);
    end
  endtask

  task automatic test_store_load();
    logic [7:0] e;
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE); exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
    cyc();
    ls_req_in = 1'b1; ls_we_in = 1'b1; ls_size_in = 2'b10;
    ls_addr_in = 32'h200; ls_wdata_in = 32'hDEADBEEF;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (k <= 4) begin
        e = exp_q.pop_front();
        if (mem_wr !== 1'b1 || mem_a !== 32'h200 + k - 1 || mem_dout !== e || ls_done_out !== 1'b0) begin
          failures++;
          $display("FAIL store_byte k=%0d got wr=%b a=%h d=%h exp wr=1 a=%h d=%h",
                   k, mem_wr, mem_a, mem_dout, 32'h200 + k - 1, e);
        end
      end else if (ls_done_out !== 1'b1 || mem_wr !== 1'b0 || if_done_out !== 1'b0) begin
        failures++;
        $display("FAIL store_done got lsd=%b wr=%b ifd=%b exp 1 0 0", ls_done_out, mem_wr, if_done_out);
      end
    end
    cyc();
    ls_we_in = 1'b0; ls_size_in = 2'b01; ls_addr_in = 32'h202;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (k <= 2) begin
        if (mem_a !== 32'h202 + k - 1 || mem_wr !== 1'b0 || ls_done_out !== 1'b0) begin
          failures++;
          $display("FAIL load_half_addr k=%0d got a=%h wr=%b done=%b exp a=%h", k, mem_a, mem_wr,
                   ls_done_out, 32'h202 + k - 1);
        end
      end else if (ls_done_out !== 1'b1 || ls_rdata_out !== 32'h0000DEAD) begin
        failures++;
        $display("FAIL load_half_done got done=%b data=%h exp done=1 data=0000DEAD", ls_done_out, ls_rdata_out);
      end
    end
    cyc();
    ls_req_in = 1'b0;
  endtask

  task automatic test_contention();
    logic [1:0] order_q[$];
    logic [1:0] got, want;
    int ls_left, if_left, dones, n;
`ifdef MEMCTRL_RR_EN
    order_q = '{2'd1, 2'd2, 2'd1, 2'd2};
`else
    order_q = '{2'd1, 2'd1, 2'd2, 2'd2};
`endif
    ls_left = 2; if_left = 2; dones = 0; n = 0;
    cyc();
    ls_req_in = 1'b1; ls_we_in = 1'b0; ls_size_in = 2'b00; ls_addr_in = 32'h100;
    if_req_in = 1'b1; if_addr_in = 32'h100;
    while ((ls_left > 0 || if_left > 0) && n < 80) begin
      cyc();
      n++;
      if (ls_left == 0) ls_req_in = 1'b0;
      if (if_left == 0) if_req_in = 1'b0;
      @(negedge clk);
      if (ls_done_out && if_done_out) begin
        checks++; failures++;
        $display("FAIL contend_both_done got ls=1 if=1 exp at most one");
      end else if (ls_done_out || if_done_out) begin
        got = ls_done_out ? 2'd1 : 2'd2;
        want = (order_q.size() > 0) ? order_q.pop_front() : 2'd0;
        dones++;
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL contend_order done#%0d got=%0d exp=%0d (1=LS 2=IF)", dones, got, want);
        end
        checks++;
        if (ls_done_out && ls_rdata_out !== 32'h00000013) begin
          failures++;
          $display("FAIL contend_ls_data got=%h exp=00000013", ls_rdata_out);
        end else if (if_done_out && if_data_out !== 32'h00000513) begin
          failures++;
          $display("FAIL contend_if_data got=%h exp=00000513", if_data_out);
        end
        if (ls_done_out) ls_left--;
        else             if_left--;
      end
    end
    cyc();
    ls_req_in = 1'b0; if_req_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ls_done_out || if_done_out) dones++;
      cyc();
    end
    checks++;
    if (dones !== 4 || ls_left != 0 || if_left != 0) begin
      failures++;
      $display("FAIL contend_count got dones=%0d ls_left=%0d if_left=%0d exp 4 0 0", dones, ls_left, if_left);
    end
  endtask

  task automatic test_flush();
    int if_seen;
    if_seen = 0;
    cyc();
    if_addr_in = 32'h400; if_req_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 3) begin
        flush_in = 1'b1; if_req_in = 1'b0;
        ls_req_in = 1'b1; ls_we_in = 1'b0; ls_size_in = 2'b00; ls_addr_in = 32'h100;
      end else begin
        flush_in = 1'b0;
      end
      @(negedge clk);
      if (if_done_out) if_seen++;
      if (k == 3 || k == 4) begin
        checks++;
        if (mem_a !== 32'd0 || ls_done_out !== 1'b0) begin
          failures++;
          $display("FAIL flush_idle k=%0d got a=%h lsd=%b exp a=0 lsd=0", k, mem_a, ls_done_out);
        end
      end else if (k == 5) begin
        checks++;
        if (mem_a !== 32'h100 || mem_wr !== 1'b0) begin
          failures++;
          $display("FAIL flush_ls_grant got a=%h wr=%b exp a=00000100 wr=0", mem_a, mem_wr);
        end
      end else if (k == 6) begin
        checks++;
        if (ls_done_out !== 1'b1 || ls_rdata_out !== 32'h00000013) begin
          failures++;
          $display("FAIL flush_ls_done got done=%b data=%h exp done=1 data=00000013", ls_done_out, ls_rdata_out);
        end
      end
    end
    cyc();
    ls_req_in = 1'b0;
    checks++;
    if (if_seen != 0) begin
      failures++;
      $display("FAIL flush_no_if_done got=%0d exp=0", if_seen);
    end
  endtask

  task automatic test_io();
    cyc();
    ls_req_in = 1'b1; ls_we_in = 1'b1; ls_size_in = 2'b00;
    ls_addr_in = 32'h30000; ls_wdata_in = 32'h00000041; io_buffer_full = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 4) io_buffer_full = 1'b0;
      @(negedge clk);
      checks++;
      if (k <= 3) begin
        if (mem_wr !== 1'b0 || ls_done_out !== 1'b0) begin
          failures++;
          $display("FAIL io_stall k=%0d got wr=%b done=%b exp wr=0 done=0", k, mem_wr, ls_done_out);
        end
      end else if (k == 4) begin
        if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h41 || ls_done_out !== 1'b0) begin
          failures++;
          $display("FAIL io_write got wr=%b a=%h d=%h exp wr=1 a=00030000 d=41", mem_wr, mem_a, mem_dout);
        end
      end else if (ls_done_out !== 1'b1 || mem_wr !== 1'b0) begin
        failures++;
        $display("FAIL io_done got done=%b wr=%b exp done=1 wr=0", ls_done_out, mem_wr);
      end
    end
    cyc();
    ls_req_in = 1'b0;
  endtask

  task automatic test_rdy_rst();
    cyc();
    ls_req_in = 1'b1; ls_we_in = 1'b0; ls_size_in = 2'b10; ls_addr_in = 32'h200;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      rdy = (k == 2 || k == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      checks++;
      if (k == 1) begin
        if (mem_a !== 32'h200) begin
          failures++;
          $display("FAIL pause_addr0 got a=%h exp a=00000200", mem_a);
        end
      end else if (k <= 4) begin
        if (mem_a !== 32'h201 || mem_wr !== 1'b0 || ls_done_out !== 1'b0) begin
          failures++;
          $display("FAIL pause_frozen k=%0d got a=%h wr=%b done=%b exp a=00000201", k, mem_a, mem_wr, ls_done_out);
        end
      end else if (k <= 6) begin
        if (mem_a !== 32'h202 + k - 5 || ls_done_out !== 1'b0) begin
          failures++;
          $display("FAIL pause_resume k=%0d got a=%h done=%b exp a=%h", k, mem_a, ls_done_out, 32'h202 + k - 5);
        end
      end else if (ls_done_out !== 1'b1 || ls_rdata_out !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL pause_done got done=%b data=%h exp done=1 data=DEADBEEF", ls_done_out, ls_rdata_out);
      end
    end
    cyc();
    ls_we_in = 1'b1; ls_addr_in = 32'h300; ls_wdata_in = 32'h11223344;
    cyc();
    @(negedge clk);
    checks++;
    if (mem_wr !== 1'b1 || mem_dout !== 8'h44) begin
      failures++;
      $display("FAIL rst_store_start got wr=%b d=%h exp wr=1 d=44", mem_wr, mem_dout);
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; ls_req_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_a, mem_dout, mem_wr, if_done_out, ls_done_out} !== 43'd0 ||
        if_data_out !== 32'd0 || ls_rdata_out !== 32'd0) begin
      failures++;
      $display("FAIL rst_abort got a=%h d=%h wr=%b ifd=%b lsd=%b if=%h ls=%h exp all 0",
               mem_a, mem_dout, mem_wr, if_done_out, ls_done_out, if_data_out, ls_rdata_out);
    end
    for (int k = 0; k < 6; k++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (if_done_out !== 1'b0 || ls_done_out !== 1'b0 || mem_wr !== 1'b0) begin
        failures++;
        $display("FAIL rst_quiet k=%0d got ifd=%b lsd=%b wr=%b exp 0 0 0", k, if_done_out, ls_done_out, mem_wr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_flush();
    test_io();
    test_rdy_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
